// File: rtl/hazard_ctrl_if.sv
// Stall/flush control bundle between the hazard sequencer and the pipeline registers.
// The sequencer uses the slave view and the pipeline uses the master view.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             id_exe_MemRead;
  logic [4:0]       id_exe_rt;
  logic             exe_branch_taken;
  logic             exe_md_start;
  logic             exe_md_is_div;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_exe_en;
  logic             id_exe_flush;
  logic             exe_mem_en;
  logic             exe_mem_flush;
  logic             mem_wb_flush;
  logic             md_busy;
  logic             md_done;
  logic [CNT_W-1:0] stall_cycles;

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_exe_MemRead, id_exe_rt,
           exe_branch_taken, exe_md_start, exe_md_is_div, mem_req, mem_ready,
    output pc_en, if_id_en, if_id_flush, id_exe_en, id_exe_flush,
           exe_mem_en, exe_mem_flush, mem_wb_flush, md_busy, md_done, stall_cycles
  );

  modport master (
    output id_rs, id_rt, id_uses_rt, id_exe_MemRead, id_exe_rt,
           exe_branch_taken, exe_md_start, exe_md_is_div, mem_req, mem_ready,
    input  pc_en, if_id_en, if_id_flush, id_exe_en, id_exe_flush,
           exe_mem_en, exe_mem_flush, mem_wb_flush, md_busy, md_done, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory freeze > mult/div > branch > load-use.
// Control outputs are combinational from the current inputs; md_done and stall_cycles are registered.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 4,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 32
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave hif
);

  typedef enum logic {RUN, MD_BUSY} state_t;

  localparam logic [5:0] MULT_LD = 6'(MULT_CYCLES - 1);
  localparam logic [5:0] DIV_LD  = 6'(DIV_CYCLES - 1);

  state_t           state, state_nxt;
  logic [5:0]       md_cnt, md_cnt_nxt;
  logic             md_done_q, md_done_nxt;
  logic [CNT_W-1:0] stall_q;
  logic             freeze, md_start, load_use;

  assign freeze   = hif.mem_req && !hif.mem_ready;
  // md_done gates the start so the op that just finished is not relaunched.
  assign md_start = (state == RUN) && hif.exe_md_start && !md_done_q;
  assign load_use = hif.id_exe_MemRead && (hif.id_exe_rt != 5'd0) &&
                    ((hif.id_exe_rt == hif.id_rs) ||
                     (hif.id_uses_rt && (hif.id_exe_rt == hif.id_rt)));

  always_comb begin
    hif.pc_en         = 1'b1;
    hif.if_id_en      = 1'b1;
    hif.if_id_flush   = 1'b0;
    hif.id_exe_en     = 1'b1;
    hif.id_exe_flush  = 1'b0;
    hif.exe_mem_en    = 1'b1;
    hif.exe_mem_flush = 1'b0;
    hif.mem_wb_flush  = 1'b0;
    hif.md_busy       = (state == MD_BUSY) && !rst;
    state_nxt         = state;
    md_cnt_nxt        = md_cnt;
    md_done_nxt       = 1'b0;

    if (rst) begin
      state_nxt = RUN;
    end else if (freeze) begin
      hif.pc_en        = 1'b0;
      hif.if_id_en     = 1'b0;
      hif.id_exe_en    = 1'b0;
      hif.exe_mem_en   = 1'b0;
      hif.mem_wb_flush = 1'b1;
      // The last mult/div cycle cannot retire while MEM is frozen.
      if (state == MD_BUSY && md_cnt != 6'd1)
        md_cnt_nxt = md_cnt - 6'd1;
    end else if (state == MD_BUSY || md_start) begin
      hif.pc_en         = 1'b0;
      hif.if_id_en      = 1'b0;
      hif.id_exe_en     = 1'b0;
      hif.exe_mem_flush = 1'b1;
      if (state == RUN) begin
        state_nxt  = MD_BUSY;
        md_cnt_nxt = hif.exe_md_is_div ? DIV_LD : MULT_LD;
      end else if (md_cnt == 6'd1) begin
        state_nxt   = RUN;
        md_cnt_nxt  = 6'd0;
        md_done_nxt = 1'b1;
      end else begin
        md_cnt_nxt = md_cnt - 6'd1;
      end
    end else if (hif.exe_branch_taken) begin
      hif.if_id_flush  = 1'b1;
      hif.id_exe_flush = 1'b1;
    end else if (load_use) begin
      hif.pc_en        = 1'b0;
      hif.if_id_en     = 1'b0;
      hif.id_exe_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      md_cnt    <= 6'd0;
      md_done_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      state     <= state_nxt;
      md_cnt    <= md_cnt_nxt;
      md_done_q <= md_done_nxt;
      if (!hif.pc_en && !(&stall_q))
        stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign hif.md_done      = md_done_q;
  assign hif.stall_cycles = stall_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS-lite pipeline; sits beside the forwarding logic and drives the enable/flush pins of PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB.
- Resolves four hazard classes:
  - load-use hazards;
  - taken branches/jumps resolved in EX;
  - multi-cycle mult/div occupancy of EX;
  - data-memory wait states.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- MULT_CYCLES, 4: total EX occupancy of a mult, in cycles. Legal range 2..63.
- DIV_CYCLES, 32: total EX occupancy of a div, in cycles. Legal range 2..63.
- CNT_W, 32: width of stall_cycles.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs  in  5  source rs of the instruction in ID.
- id_rt  in  5  source rt of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt.
- id_exe_MemRead  in  1  EX instruction is a load.
- id_exe_rt  in  5  load destination register in EX.
- exe_branch_taken  in  1  branch/jump taken, resolved in EX.
- exe_md_start  in  1  EX holds a mult/div.
- exe_md_is_div  in  1  qualifies exe_md_start: 1 = div.
- mem_req  in  1  MEM stage is accessing data memory.
- mem_ready  in  1  data memory completes this cycle.
- pc_en  out  1  PC update enable.
- if_id_en  out  1  IF/ID enable.
- if_id_flush  out  1  IF/ID loads bubble.
- id_exe_en  out  1  ID/EXE enable.
- id_exe_flush  out  1  ID/EXE loads bubble.
- exe_mem_en  out  1  EXE/MEM enable.
- exe_mem_flush  out  1  EXE/MEM loads bubble.
- mem_wb_flush  out  1  MEM/WB loads bubble.
- md_busy  out  1  state == MD_BUSY.
- md_done  out  1  registered 1-cycle pulse: mult/div result valid, EX instruction advances.
- stall_cycles  out  CNT_W  count of cycles with pc_en == 0.

Behaviour:
- State machine: RUN and MD_BUSY. Internal 6-bit counter md_cnt.
- Reset:
  - state = RUN, md_cnt = 0, md_done = 0, stall_cycles = 0.
  - While rst = 1, all *_en = 1, all *_flush = 0, md_busy = 0.
- Defaults: all enables = 1, all flushes = 0.
- Combinational outputs are evaluated in the priority order below; the highest active rule wins.
- Priority 1, memory freeze:
  - Condition: mem_req && !mem_ready, in any state.
  - pc_en = if_id_en = id_exe_en = exe_mem_en = 0, mem_wb_flush = 1.
  - All other flushes = 0, so exe_branch_taken is ignored that cycle.
  - The branch is held in EX and acted on when the freeze lifts.
- Priority 2, MD_BUSY:
  - pc_en = if_id_en = id_exe_en = 0, exe_mem_flush = 1.
  - md_cnt decrements every cycle. It is held at 1 while a memory freeze is active.
  - When md_cnt == 1 and there is no freeze: state <= RUN, md_done <= 1 (next cycle).
- Priority 3, md start:
  - Condition: RUN && exe_md_start && !md_done.
  - This cycle stalls exactly as in MD_BUSY.
  - md_cnt <= (exe_md_is_div ? DIV_CYCLES : MULT_CYCLES) - 1, state <= MD_BUSY.
  - Total stall equals the parameter value N. md_done is high in cycle N+1, when EX advances.
  - exe_md_start is ignored while md_done = 1, so the finished op is not restarted.
- Priority 4, branch:
  - Condition: exe_branch_taken.
  - if_id_flush = 1, id_exe_flush = 1, pc_en = 1 (PC loads the target).
  - Load-use is suppressed, because the ID instruction is squashed.
- Priority 5, load-use:
  - Condition: id_exe_MemRead && id_exe_rt != 0 && (id_exe_rt == id_rs || (id_uses_rt && id_exe_rt == id_rt)).
  - pc_en = 0, if_id_en = 0, id_exe_flush = 1.
  - Exactly one stall cycle; forwarding covers the rest.
- md_done is a registered pulse, cleared in every cycle that does not set it.
- stall_cycles increments when pc_en == 0 and saturates at 2^CNT_W - 1.
- A reset asserted mid-mult/div aborts the operation with no md_done pulse.

Test Plan:
- Load-use: lw $8 in EX, ID add uses $8 as rs → one cycle with pc_en = 0, if_id_en = 0, id_exe_flush = 1; next cycle all enables = 1; stall_cycles = 1. Repeat with id_exe_rt = 0 → no stall.
- Taken branch concurrent with a load-use match → if_id_flush = id_exe_flush = 1, pc_en = 1, no stall; stall_cycles unchanged.
- Mult with MULT_CYCLES = 4: exe_md_start held high → pc_en = 0 for exactly 4 cycles, md_busy high for 3, md_done high in cycle 5, no restart. Div → 32 stall cycles, stall_cycles = 32.
- Memory wait: mem_req = 1, mem_ready = 0 for 3 cycles during an exe_branch_taken → full freeze with mem_wb_flush = 1 for 3 cycles, then the branch flush occurs in cycle 4.
- Mem freeze overlapping the final div cycle → md_cnt holds at 1, md_done delayed until 1 cycle after mem_ready.
- Reset asserted in the 10th cycle of a div → next cycle state RUN, md_busy = 0, md_done = 0, stall_cycles = 0; a subsequent mult behaves normally.
